// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32 hazard detection unit.
// Cause-bit positions, the x0 register index and the cause vector type.
package hazard_pkg;

    localparam int CAUSE_RAW = 0;
    localparam int CAUSE_LU  = 1;
    localparam int CAUSE_CTL = 2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef logic [2:0] hz_cause_t;

endpackage

// File: rtl/hazard_reg_match.sv
// Compares one pipeline destination register against both ID sources.
// x0 never matches, even when its write enable is high.
module hazard_reg_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hit
);

    logic w_nz;

    assign w_nz  = (i_rd != REG_ADDR_W'(REG_X0));
    assign o_hit = i_we && w_nz
                && ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/bubble generation for the 5-stage pipeline plus cause/timeout regs.
// Optional macro HAZARD_PERF_EN adds three 32-bit stall performance counters.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int WB_BYPASS  = 0,
    parameter int MAX_STALL  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  id_branch,
    input  logic                  id_jump,
    output logic                  stall,
    output logic                  bubble,
    output logic [2:0]            hazard_cause,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_loaduse_cycles,
    output logic [31:0]           perf_ctrl_cycles,
`endif
    output logic                  stall_timeout
);

    localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);
    localparam logic [7:0] RUN_SAT     = 8'hFF;

    logic      w_ex_hit;
    logic      w_mem_hit;
    logic      w_wb_hit;
    logic      w_wb_raw;
    logic      w_raw_hz;
    logic      w_lu_hz;
    logic      w_ctl_hz;
    logic      w_stall;
    hz_cause_t w_cause;
    logic [7:0] w_run_nxt;

    hz_cause_t  r_cause;
    logic [7:0] r_run;
    logic       r_timeout;

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_match (
        .i_rd  (ex_rd),
        .i_we  (ex_reg_write),
        .i_rs1 (id_rs1),
        .i_rs2 (id_rs2),
        .o_hit (w_ex_hit)
    );

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_match (
        .i_rd  (mem_rd),
        .i_we  (mem_reg_write),
        .i_rs1 (id_rs1),
        .i_rs2 (id_rs2),
        .o_hit (w_mem_hit)
    );

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_wb_match (
        .i_rd  (wb_rd),
        .i_we  (wb_reg_write),
        .i_rs1 (id_rs1),
        .i_rs2 (id_rs2),
        .o_hit (w_wb_hit)
    );

    // A write-through register file already forwards the WB value.
    assign w_wb_raw = (WB_BYPASS == 0) ? w_wb_hit : 1'b0;
    assign w_raw_hz = w_ex_hit | w_mem_hit | w_wb_raw;

    // Load-use looks only at the load flag, not at ex_reg_write.
    assign w_lu_hz  = ex_mem_read
                   && (ex_rd != REG_ADDR_W'(REG_X0))
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign w_ctl_hz = id_branch | id_jump;
    assign w_stall  = w_raw_hz | w_lu_hz | w_ctl_hz;

    assign stall         = w_stall;
    assign bubble        = w_stall;
    assign hazard_cause  = r_cause;
    assign stall_timeout = r_timeout;

    // Assemble the cause vector and the next stall-run length.
    always_comb begin
        w_cause            = '0;
        w_cause[CAUSE_RAW] = w_raw_hz;
        w_cause[CAUSE_LU]  = w_lu_hz;
        w_cause[CAUSE_CTL] = w_ctl_hz;
        w_run_nxt          = 8'd0;
        if (w_stall) begin
            w_run_nxt = (r_run == RUN_SAT) ? r_run : r_run + 8'd1;
        end
    end

    // Cause capture, stall-run counter and sticky runaway flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause   <= '0;
            r_run     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cause   <= w_cause;
            r_run     <= w_run_nxt;
            if (w_run_nxt == MAX_STALL_C) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_ctl;

    assign perf_stall_cycles   = r_perf_stall;
    assign perf_loaduse_cycles = r_perf_lu;
    assign perf_ctrl_cycles    = r_perf_ctl;

    // Wrapping event counters for stall, load-use and control cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_lu    <= '0;
            r_perf_ctl   <= '0;
        end else begin
            r_perf_stall <= r_perf_stall + 32'(w_stall);
            r_perf_lu    <= r_perf_lu + 32'(w_lu_hz);
            r_perf_ctl   <= r_perf_ctl + 32'(w_ctl_hz);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit (WB_BYPASS = 0 and 1 instances).
// Directed test-plan steps followed by randomized traffic with random resets.
module tb_hazard_detection_unit;

    localparam int MAXS = 16;

    typedef struct {
        logic        st;
        logic [2:0]  cause;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pl;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0;
    logic [4:0] ex_rd = '0, mem_rd = '0, wb_rd = '0;
    logic ex_reg_write = 0, mem_reg_write = 0, wb_reg_write = 0;
    logic ex_mem_read = 0, id_branch = 0, id_jump = 0;

    logic       stall_o [2];
    logic       bubble_o[2];
    logic [2:0] cause_o [2];
    logic       to_o    [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] ps_o[2], pl_o[2], pc_o[2];
`endif

    exp_t q0[$];
    exp_t q1[$];

    logic [2:0]  m_cause[2];
    int          m_run  [2];
    bit          m_to   [2];
    logic [31:0] m_ps[2], m_pl[2], m_pc[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hazard_detection_unit #(
            .REG_ADDR_W(5), .WB_BYPASS(g), .MAX_STALL(MAXS)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .id_rs1        (id_rs1),
            .id_rs2        (id_rs2),
            .ex_rd         (ex_rd),
            .mem_rd        (mem_rd),
            .wb_rd         (wb_rd),
            .ex_reg_write  (ex_reg_write),
            .mem_reg_write (mem_reg_write),
            .wb_reg_write  (wb_reg_write),
            .ex_mem_read   (ex_mem_read),
            .id_branch     (id_branch),
            .id_jump       (id_jump),
            .stall         (stall_o[g]),
            .bubble        (bubble_o[g]),
            .hazard_cause  (cause_o[g]),
`ifdef HAZARD_PERF_EN
            .perf_stall_cycles   (ps_o[g]),
            .perf_loaduse_cycles (pl_o[g]),
            .perf_ctrl_cycles    (pc_o[g]),
`endif
            .stall_timeout (to_o[g])
        );
    end

    // Reference: hazard causes straight from the pipeline rules.
    function automatic logic [2:0] f_cause(int v);
        logic [4:0] rd[3];
        bit         we[3];
        bit         raw = 0;
        bit         lu;
        rd = '{ex_rd, mem_rd, wb_rd};
        we = '{ex_reg_write, mem_reg_write, wb_reg_write};
        for (int i = 0; i < 3; i++) begin
            if (i == 2 && v == 1) continue;
            if (we[i] && rd[i] != 0 && (rd[i] == id_rs1 || rd[i] == id_rs2))
                raw = 1;
        end
        lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        return {id_branch | id_jump, lu, raw};
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            m_cause[v] = 0; m_run[v] = 0; m_to[v] = 0;
            m_ps[v] = 0; m_pl[v] = 0; m_pc[v] = 0;
        end
    endtask

    task automatic model_edge();
        for (int v = 0; v < 2; v++) begin
            logic [2:0] c;
            bit st;
            c  = f_cause(v);
            st = (c != 0);
            m_cause[v] = c;
            m_run[v]   = st ? ((m_run[v] < 255) ? m_run[v] + 1 : 255) : 0;
            if (m_run[v] == MAXS) m_to[v] = 1;
            m_ps[v] += 32'(st);
            m_pl[v] += 32'(c[1]);
            m_pc[v] += 32'(c[2]);
        end
    endtask

    task automatic set_in(input int rs1, rs2, erd, mrd, wrd,
                          input bit ew, mw, ww, mr, br, jp);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        ex_rd = 5'(erd); mem_rd = 5'(mrd); wb_rd = 5'(wrd);
        ex_reg_write = ew; mem_reg_write = mw; wb_reg_write = ww;
        ex_mem_read = mr; id_branch = br; id_jump = jp;
    endtask

    // One cycle: model the edge, apply new inputs, push expectations.
    task automatic step(input int rs1, rs2, erd, mrd, wrd,
                        input bit ew, mw, ww, mr, br, jp, r);
        exp_t e;
        @(posedge clk);
        if (rst) model_clear();
        else     model_edge();
        #1;
        set_in(rs1, rs2, erd, mrd, wrd, ew, mw, ww, mr, br, jp);
        rst = r;
        if (r) model_clear();
        for (int v = 0; v < 2; v++) begin
            e.st    = (f_cause(v) != 0);
            e.cause = m_cause[v];
            e.to    = m_to[v];
            e.ps    = m_ps[v];
            e.pl    = m_pl[v];
            e.pc    = m_pc[v];
            if (v == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int v,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[bypass=%0d] t=%0t got=%0h want=%0h",
                     name, v, $time, act, exp);
        end
    endtask

    task automatic compare(input int v, input exp_t e);
        chk("stall", v, stall_o[v], e.st);
        chk("bubble", v, bubble_o[v], e.st);
        chk("hazard_cause", v, cause_o[v], e.cause);
        chk("stall_timeout", v, to_o[v], e.to);
`ifdef HAZARD_PERF_EN
        chk("perf_stall", v, ps_o[v], e.ps);
        chk("perf_loaduse", v, pl_o[v], e.pl);
        chk("perf_ctrl", v, pc_o[v], e.pc);
`endif
    endtask

    // Monitor: away from the active edge, pop and compare each pending entry.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare(0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare(1, e);
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        // rs1 rs2 exrd memrd wbrd ew mw ww mr br jp rst
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
        step(3, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(5, 9, 5, 9, 5, 1, 1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (MAXS) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drain", 0, q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
